// File: rtl/hover_controller.sv
// hover_controller: debounced button cursor over the catalog grid or basket slots, with select events
// Ports: CLK/RST (sync, active-high); BTN raw active-low {select,down,right,left}; SW2 mode (0 catalog, 1 basket);
// FrameStart loads HighlightedProductList; BasketCount occupied slots; SelectValid/SelectID/SelectMode select event.
module hover_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_CNT_WIDTH = 19,
  parameter int NUM_PRODUCTS = 12
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [3:0]              BTN,
  input  logic                    SW2,
  input  logic                    FrameStart,
  input  logic [3:0]              BasketCount,
  output logic [NUM_PRODUCTS-1:0] HighlightedProductList,
  output logic                    SelectValid,
  output logic [3:0]              SelectID,
  output logic                    SelectMode
);
  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} db_state_t;
  localparam logic [DB_CNT_WIDTH-1:0] DB_LAST = DB_CNT_WIDTH'(DEBOUNCE_CYCLES);
  logic [3:0] r_btn_s1, r_btn_s2;
  logic r_sw_s1, r_sw_s2, r_sw_d;
  db_state_t [3:0] r_st, w_st_nx;
  logic [3:0][DB_CNT_WIDTH-1:0] r_cnt, w_cnt_nx;
  logic [3:0] w_lvl, w_ev, w_act;
  logic [3:0] r_cat, r_bsk, w_cat_nx, w_bsk_nx, w_n, w_nm1;
  logic [1:0] w_row, w_col;
  logic w_mode, w_sel, w_left, w_right, w_down, w_fire;
  logic [NUM_PRODUCTS-1:0] w_hl_nx;
  assign w_lvl = ~r_btn_s2;
  assign w_mode = r_sw_s2;
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_st_nx[i] = r_st[i];
      w_cnt_nx[i] = r_cnt[i];
      w_ev[i] = 1'b0;
      case (r_st[i])
        RELEASED: if (w_lvl[i]) begin
          w_st_nx[i] = PRESS_WAIT;
          w_cnt_nx[i] = '0;
        end
        PRESS_WAIT: if (!w_lvl[i]) begin
          w_st_nx[i] = RELEASED;
          w_cnt_nx[i] = '0;
        end else if (r_cnt[i] + DB_CNT_WIDTH'(1) == DB_LAST) begin
          w_st_nx[i] = PRESSED;
          w_cnt_nx[i] = '0;
          w_ev[i] = 1'b1;
        end else w_cnt_nx[i] = r_cnt[i] + DB_CNT_WIDTH'(1);
        PRESSED: if (!w_lvl[i]) begin
          w_st_nx[i] = RELEASE_WAIT;
          w_cnt_nx[i] = '0;
        end
        RELEASE_WAIT: if (w_lvl[i]) begin
          w_st_nx[i] = PRESSED;
          w_cnt_nx[i] = '0;
        end else if (r_cnt[i] + DB_CNT_WIDTH'(1) == DB_LAST) begin
          w_st_nx[i] = RELEASED;
          w_cnt_nx[i] = '0;
        end else w_cnt_nx[i] = r_cnt[i] + DB_CNT_WIDTH'(1);
        default: begin
          w_st_nx[i] = RELEASED;
          w_cnt_nx[i] = '0;
        end
      endcase
    end
  end
  // events are discarded in the cycle the synced mode switch changes
  assign w_act = (r_sw_s2 != r_sw_d) ? 4'b0 : w_ev;
  assign w_sel = w_act[3];
  assign w_left = w_act[0] & ~w_act[3];
  assign w_right = w_act[1] & ~|{w_act[3], w_act[0]};
  assign w_down = w_act[2] & ~|{w_act[3], w_act[1:0]};
  assign w_row = r_cat[3:2];
  assign w_col = r_cat[1:0];
  assign w_n = BasketCount;
  assign w_nm1 = w_n - 4'd1;
  assign w_cat_nx = w_mode ? r_cat :
                    w_left ? {w_row, w_col - 2'd1} :
                    w_right ? {w_row, w_col + 2'd1} :
                    w_down ? {(w_row == 2'd2) ? 2'd0 : w_row + 2'd1, w_col} : r_cat;
  // clamping to the occupied range wins over any movement in the same cycle
  assign w_bsk_nx = (w_n == 4'd0) ? 4'd0 :
                    (r_bsk >= w_n) ? w_nm1 :
                    !w_mode ? r_bsk :
                    w_left ? ((r_bsk == 4'd0) ? w_nm1 : r_bsk - 4'd1) :
                    (w_right | w_down) ? ((r_bsk == w_nm1) ? 4'd0 : r_bsk + 4'd1) : r_bsk;
  assign w_fire = w_sel & (~w_mode | (w_n != 4'd0));
  assign w_hl_nx = w_mode ? ((w_n != 4'd0) ? NUM_PRODUCTS'(1) << r_bsk : '0) : NUM_PRODUCTS'(1) << r_cat;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_btn_s1 <= 4'hF;
      r_btn_s2 <= 4'hF;
      r_sw_s1 <= 1'b0;
      r_sw_s2 <= 1'b0;
      r_sw_d <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_st[i] <= RELEASED;
        r_cnt[i] <= '0;
      end
      r_cat <= 4'd0;
      r_bsk <= 4'd0;
      HighlightedProductList <= '0;
      SelectValid <= 1'b0;
      SelectID <= 4'd0;
      SelectMode <= 1'b0;
    end else begin
      r_btn_s1 <= BTN;
      r_btn_s2 <= r_btn_s1;
      r_sw_s1 <= SW2;
      r_sw_s2 <= r_sw_s1;
      r_sw_d <= r_sw_s2;
      r_st <= w_st_nx;
      r_cnt <= w_cnt_nx;
      r_cat <= w_cat_nx;
      r_bsk <= w_bsk_nx;
      if (FrameStart) HighlightedProductList <= w_hl_nx;
      SelectValid <= w_fire;
      if (w_fire) begin
        SelectID <= w_mode ? r_bsk : r_cat;
        SelectMode <= w_mode;
      end
    end
  end
endmodule

// File: tb/tb_hover_controller.sv
// tb_hover_controller: directed checks of cursor movement, debounce, arbitration, basket clamp and reset
module tb_hover_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] btn = 4'hF;
  logic sw2 = 1'b0;
  logic fs = 1'b0;
  logic [3:0] bc = 4'd0;
  logic [11:0] hl;
  logic sv;
  logic [3:0] sid;
  logic smode;
  int total = 0;
  int bad = 0;
  int sv_cnt = 0;
  hover_controller #(.DEBOUNCE_CYCLES(4), .DB_CNT_WIDTH(3), .NUM_PRODUCTS(12)) dut (
    .CLK(clk), .RST(rst), .BTN(btn), .SW2(sw2), .FrameStart(fs), .BasketCount(bc),
    .HighlightedProductList(hl), .SelectValid(sv), .SelectID(sid), .SelectMode(smode)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (sv) sv_cnt++;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic frame();
    fs = 1'b1;
    tick(1);
    fs = 1'b0;
  endtask
  task automatic press(input logic [3:0] mask);
    btn = ~mask;
    tick(10);
    btn = 4'hF;
    tick(12);
  endtask
  initial begin
    tick(3);
    rst = 1'b0;
    chk("rst_hl", hl, 12'h000);
    chk("rst_sv", {11'b0, sv}, 12'h0);
    chk("rst_sid", {8'b0, sid}, 12'h0);
    chk("rst_smode", {11'b0, smode}, 12'h0);
    tick(5);
    chk("hl_before_frame", hl, 12'h000);
    frame();
    chk("hl_first_frame", hl, 12'h001);
    press(4'b0010); frame(); chk("cat_r1", hl, 12'h002);
    press(4'b0010); frame(); chk("cat_r2", hl, 12'h004);
    press(4'b0010); frame(); chk("cat_r3", hl, 12'h008);
    press(4'b0010); frame(); chk("cat_r4_wrap", hl, 12'h001);
    press(4'b0100); frame(); chk("cat_down", hl, 12'h010);
    press(4'b0001); frame(); chk("cat_left_wrap", hl, 12'h080);
    btn = 4'b1101;
    tick(3);
    btn = 4'hF;
    tick(12);
    frame();
    chk("glitch_no_move", hl, 12'h080);
    press(4'b0010); frame(); chk("held_one_move", hl, 12'h010);
    press(4'b0010); frame(); chk("cat_idx5", hl, 12'h020);
    sv_cnt = 0;
    press(4'b1001);
    chk("sel_pulses", 12'(sv_cnt), 12'd1);
    chk("sel_id", {8'b0, sid}, 12'd5);
    chk("sel_mode", {11'b0, smode}, 12'd0);
    frame();
    chk("sel_left_dropped", hl, 12'h020);
    sw2 = 1'b1;
    bc = 4'd3;
    tick(5);
    frame();
    chk("bsk_start", hl, 12'h001);
    press(4'b0001); frame(); chk("bsk_left_wrap", hl, 12'h004);
    press(4'b0010); frame(); chk("bsk_right_wrap", hl, 12'h001);
    press(4'b0001);
    bc = 4'd2;
    tick(1);
    frame();
    chk("bsk_clamp", hl, 12'h002);
    sv_cnt = 0;
    press(4'b1000);
    chk("bsk_sel_pulses", 12'(sv_cnt), 12'd1);
    chk("bsk_sel_id", {8'b0, sid}, 12'd1);
    chk("bsk_sel_mode", {11'b0, smode}, 12'd1);
    bc = 4'd0;
    tick(1);
    frame();
    chk("bsk_empty_hl", hl, 12'h000);
    press(4'b1000);
    press(4'b0010);
    chk("bsk_empty_no_sel", 12'(sv_cnt), 12'd1);
    chk("bsk_empty_sid_hold", {8'b0, sid}, 12'd1);
    bc = 4'd3;
    tick(1);
    frame();
    chk("bsk_empty_reset_idx", hl, 12'h001);
    sw2 = 1'b0;
    tick(5);
    frame();
    chk("cat_retained", hl, 12'h020);
    sv_cnt = 0;
    btn = 4'b0111;
    tick(5);
    rst = 1'b1;
    tick(1);
    chk("rst6_hl", hl, 12'h000);
    chk("rst6_sid", {8'b0, sid}, 12'h0);
    chk("rst6_smode", {11'b0, smode}, 12'h0);
    btn = 4'hF;
    tick(2);
    rst = 1'b0;
    tick(15);
    chk("rst6_no_sel", 12'(sv_cnt), 12'd0);
    frame();
    chk("rst6_cat0", hl, 12'h001);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
